// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the clock counter, edits hours then minutes
// from debounced buttons, and commits the result with a one-cycle load pulse.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned BLINK_HALF  = 250
) (
  input  logic       kh_clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       fmt_12,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [4:0] load_hr,
  output logic [5:0] load_min,
  output logic       blink_hr,
  output logic       blink_min,
  output logic [1:0] state
);

  localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  state_t             st;
  state_t             st_nxt;
  logic               mode_prev;
  logic               inc_prev;
  logic               dec_prev;
  logic               mode_edge;
  logic               inc_edge;
  logic               dec_edge;
  logic               any_edge;
  logic               inc_only;
  logic               dec_only;
  logic [4:0]         hmax;
  logic [4:0]         edit_hr;
  logic [4:0]         hr_nxt;
  logic [5:0]         edit_min;
  logic [5:0]         min_nxt;
  logic [IDLE_W-1:0]  idle;
  logic [IDLE_W-1:0]  idle_nxt;
  logic [BLINK_W-1:0] bcnt;
  logic [BLINK_W-1:0] bcnt_nxt;
  logic               phase;
  logic               phase_nxt;
  logic               editing;

  assign mode_edge = mode_btn & ~mode_prev;
  assign inc_edge  = inc_btn & ~inc_prev;
  assign dec_edge  = dec_btn & ~dec_prev;
  assign any_edge  = mode_edge | inc_edge | dec_edge;
  assign inc_only  = inc_edge & ~dec_edge;
  assign dec_only  = dec_edge & ~inc_edge;
  assign hmax      = fmt_12 ? 5'd11 : 5'd23;
  assign editing   = (st == SET_HR) || (st == SET_MIN);
  assign load_hr   = edit_hr;
  assign load_min  = edit_min;
  assign state     = st;

  // Next state, edit fields, idle timeout and blink phase
  always_comb begin
    st_nxt    = st;
    hr_nxt    = edit_hr;
    min_nxt   = edit_min;
    idle_nxt  = idle;
    bcnt_nxt  = bcnt;
    phase_nxt = phase;

    case (st)
      RUN: begin
        if (mode_edge) begin
          st_nxt   = SET_HR;
          hr_nxt   = (cur_hr > hmax) ? 5'd0 : cur_hr;
          min_nxt  = cur_min;
          idle_nxt = '0;
        end
      end
      SET_HR: begin
        if (mode_edge)           st_nxt = SET_MIN;
        else if (inc_only)       hr_nxt = (edit_hr >= hmax) ? 5'd0 : edit_hr + 5'd1;
        else if (dec_only)       hr_nxt = (edit_hr == 5'd0) ? hmax : edit_hr - 5'd1;
        else if (edit_hr > hmax) hr_nxt = 5'd0;
      end
      SET_MIN: begin
        if (mode_edge)     st_nxt  = COMMIT;
        else if (inc_only) min_nxt = (edit_min >= 6'd59) ? 6'd0 : edit_min + 6'd1;
        else if (dec_only) min_nxt = (edit_min == 6'd0) ? 6'd59 : edit_min - 6'd1;
        // a format change while on minutes must not leave hours out of range
        if (edit_hr > hmax) hr_nxt = 5'd0;
      end
      default: st_nxt = RUN;
    endcase

    // any edge restarts the idle window; expiry only applies without an edge
    if (editing) begin
      if (any_edge)                idle_nxt = '0;
      else if (idle == IDLE_LAST)  st_nxt   = RUN;
      else                         idle_nxt = idle + IDLE_W'(1);
    end

    // blink restarts shown on entry to each edit field
    if ((st_nxt != st) && ((st_nxt == SET_HR) || (st_nxt == SET_MIN))) begin
      bcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end else if (editing) begin
      if (bcnt == BLINK_LAST) begin
        bcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        bcnt_nxt = bcnt + BLINK_W'(1);
      end
    end
  end

  // State, edit registers and registered outputs
  always_ff @(posedge kh_clk) begin
    if (!reset) begin
      st        <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      dec_prev  <= 1'b1;
      edit_hr   <= '0;
      edit_min  <= '0;
      idle      <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      run_en    <= 1'b1;
      load      <= 1'b0;
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      st        <= st_nxt;
      mode_prev <= mode_btn;
      inc_prev  <= inc_btn;
      dec_prev  <= dec_btn;
      edit_hr   <= hr_nxt;
      edit_min  <= min_nxt;
      idle      <= idle_nxt;
      bcnt      <= bcnt_nxt;
      phase     <= phase_nxt;
      run_en    <= (st_nxt == RUN);
      load      <= (st_nxt == COMMIT);
      blink_hr  <= (st_nxt == SET_HR) & phase_nxt;
      blink_min <= (st_nxt == SET_MIN) & phase_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the setting procedure.
module tb_clock_set_ctrl;

  localparam int TO = 20;
  localparam int BH = 4;

  logic       kh_clk = 1'b0;
  logic       reset;
  logic       mode_btn, inc_btn, dec_btn, fmt_12;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       run_en, load, blink_hr, blink_min;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  // model: mode 0=run 1=hours 2=minutes 3=commit
  int m_st, m_hr, m_min, m_since, m_age;
  bit m_pm, m_pi, m_pd;

  clock_set_ctrl #(.TIMEOUT_CYC(TO), .BLINK_HALF(BH)) dut (
    .kh_clk    (kh_clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn),
    .fmt_12    (fmt_12),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .run_en    (run_en),
    .load      (load),
    .load_hr   (load_hr),
    .load_min  (load_min),
    .blink_hr  (blink_hr),
    .blink_min (blink_min),
    .state     (state)
  );

  always #5 kh_clk = ~kh_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    bit em, ei, ed;
    int hmax, s;
    if (!reset) begin
      m_st = 0; m_hr = 0; m_min = 0; m_since = 0; m_age = 0;
      m_pm = 1; m_pi = 1; m_pd = 1;
    end else begin
      em = mode_btn && !m_pm;
      ei = inc_btn && !m_pi;
      ed = dec_btn && !m_pd;
      m_pm = mode_btn; m_pi = inc_btn; m_pd = dec_btn;
      hmax = fmt_12 ? 11 : 23;
      s = m_st;
      case (s)
        0: if (em) begin
          m_st = 1; m_since = 0; m_age = 0;
          m_hr = (int'(cur_hr) > hmax) ? 0 : int'(cur_hr);
          m_min = int'(cur_min);
        end
        1: if (em) begin
          m_st = 2; m_age = 0;
        end else begin
          m_age++;
          if (ei && !ed)      m_hr = (m_hr >= hmax) ? 0 : m_hr + 1;
          else if (ed && !ei) m_hr = (m_hr == 0) ? hmax : m_hr - 1;
          else if (m_hr > hmax) m_hr = 0;
        end
        2: begin
          if (em) m_st = 3;
          else begin
            m_age++;
            if (ei && !ed)      m_min = (m_min + 1) % 60;
            else if (ed && !ei) m_min = (m_min + 59) % 60;
          end
          if (m_hr > hmax) m_hr = 0;
        end
        default: m_st = 0;
      endcase
      if (s == 1 || s == 2) begin
        if (em || ei || ed)       m_since = 0;
        else if (m_since == TO-1) m_st = 0;
        else                      m_since++;
      end
    end
  endtask

  task automatic check_all();
    check("state",     int'(state),     m_st);
    check("run_en",    int'(run_en),    int'(m_st == 0));
    check("load",      int'(load),      int'(m_st == 3));
    check("load_hr",   int'(load_hr),   m_hr);
    check("load_min",  int'(load_min),  m_min);
    check("blink_hr",  int'(blink_hr),  int'(m_st == 1 && ((m_age / BH) % 2) == 1));
    check("blink_min", int'(blink_min), int'(m_st == 2 && ((m_age / BH) % 2) == 1));
  endtask

  task automatic cyc();
    model_step();
    @(posedge kh_clk);
    #1;
    check_all();
  endtask

  task automatic press(input int which);
    case (which)
      0:       mode_btn = 1'b1;
      1:       inc_btn  = 1'b1;
      default: dec_btn  = 1'b1;
    endcase
    cyc();
    mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    bit saw_load;
    logic [15:0] pat;
    reset = 1'b0; mode_btn = 1'b1; inc_btn = 1'b0; dec_btn = 1'b0;
    fmt_12 = 1'b0; cur_hr = 5'd0; cur_min = 6'd0;

    // reset with mode held: no transition until the button rises again
    cyc(); cyc();
    check("rst_run_en", int'(run_en), 1);
    check("rst_state", int'(state), 0);
    reset = 1'b1;
    cyc(); cyc();
    check("held_no_edge", int'(state), 0);
    mode_btn = 1'b0; cyc();
    cur_hr = 5'd22; cur_min = 6'd15;
    mode_btn = 1'b1; cyc();
    check("enter_hr", int'(state), 1);
    check("capture_hr", int'(load_hr), 22);
    mode_btn = 1'b0; cyc();
    repeat (3) press(1);
    check("inc_wrap_hr", int'(load_hr), 1);
    press(0);
    check("enter_min", int'(state), 2);
    repeat (16) press(2);
    check("dec_wrap_min", int'(load_min), 59);
    mode_btn = 1'b1; cyc();
    check("commit_load", int'(load), 1);
    check("commit_hr", int'(load_hr), 1);
    check("commit_min", int'(load_min), 59);
    check("commit_run_en", int'(run_en), 0);
    mode_btn = 1'b0; cyc();
    check("post_load", int'(load), 0);
    check("post_run_en", int'(run_en), 1);

    // 12-hour clamp and wrap, then format change
    fmt_12 = 1'b1; cur_hr = 5'd15; cur_min = 6'd30;
    press(0);
    check("fmt12_clamp", int'(load_hr), 0);
    press(2);
    check("fmt12_dec", int'(load_hr), 11);
    press(1);
    check("fmt12_inc", int'(load_hr), 0);
    fmt_12 = 1'b0;
    press(2);
    check("fmt24_dec", int'(load_hr), 23);
    press(0);
    inc_btn = 1'b1; dec_btn = 1'b1; cyc();
    check("incdec_same", int'(load_min), 30);
    inc_btn = 1'b0; dec_btn = 1'b0; cyc();
    press(0);
    press(0);
    mode_btn = 1'b1; inc_btn = 1'b1; cyc();
    check("mode_over_inc_st", int'(state), 2);
    check("mode_over_inc_hr", int'(load_hr), 15);
    mode_btn = 1'b0; inc_btn = 1'b0; cyc();
    mode_btn = 1'b1; cyc();
    check("in_commit", int'(state), 3);
    reset = 1'b0; mode_btn = 1'b0; cyc();
    check("rst_commit_load", int'(load), 0);
    check("rst_commit_state", int'(state), 0);
    reset = 1'b1; cyc();

    // timeout without and with an intervening inc edge
    for (int t = 0; t < 2; t++) begin
      saw_load = 1'b0;
      mode_btn = 1'b1; cyc();
      mode_btn = 1'b0;
      n = (state == 2'd1) ? 1 : 0;
      for (int j = 1; j <= 60 && state == 2'd1; j++) begin
        inc_btn = (t == 1 && j == 15);
        cyc();
        saw_load |= load;
        if (state == 2'd1) n++;
      end
      inc_btn = 1'b0;
      check(t == 0 ? "timeout_len" : "timeout_restart", n, t == 0 ? TO : TO + 15);
      check("timeout_no_load", int'(saw_load), 0);
      cyc();
    end

    // blink pattern from entry to hours
    pat = 16'b0000111100001111;
    mode_btn = 1'b1; cyc();
    mode_btn = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) cyc();
      check("blink_pat", int'(blink_hr), int'(pat[15-j]));
      check("blink_min_off", int'(blink_min), 0);
    end

    // random button traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 11) == 0) inc_btn  = ~inc_btn;
      if ($urandom_range(0, 11) == 0) dec_btn  = ~dec_btn;
      if ($urandom_range(0, 99) == 0) fmt_12   = ~fmt_12;
      cur_hr  = 5'($urandom_range(0, 31));
      cur_min = 6'($urandom_range(0, 59));
      reset   = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
